alu_issue_ctrl: RTL and testbench

Sequencing front end for the combinational ALU: accepts 9-bit ALU instructions over a valid/ready handshake, decodes them into ALU opcode, enable and register-file read addresses, captures the ALU result and drives the register-file write port. It sits between instruction fetch and the ALU/register file in the CSE141L datapath. It also owns the compare flags (Equals, Lt) and a retired-instruction counter.

---
 rtl/alu_issue_ctrl_pkg.sv | 35 +++
 rtl/alu_issue_ctrl_if.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 102 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, issue states,
// and the bit positions of the fields in a 9-bit instruction.
package alu_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        mcADD = 3'd0,
        mcSUB = 3'd1,
        mcAND = 3'd2,
        mcORR = 3'd3,
        mcXOR = 3'd4,
        mcRXR = 3'd5,
        mcLSL = 3'd6,
        mcLSR = 3'd7
    } op_mne;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } issue_state_e;

    localparam int INSTR_W = 9;
    localparam int FIELD_W = 3;
    localparam int OP_LSB  = 6;
    localparam int RD_LSB  = 3;
    localparam int RB_LSB  = 0;

    function automatic logic [FIELD_W-1:0] fld(
        input logic [INSTR_W-1:0] ins,
        input int                 lsb
    );
        return ins[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU and register-file signals of the issue controller.
// The controller takes the slave side; fetch/ALU/register file take master.
interface alu_issue_ctrl_if
    import alu_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [INSTR_W-1:0] Instr;
    logic               InstrValid;
    logic               InstrReady;
    logic [2:0]         AluOp;
    logic               AluEn;
    logic [2:0]         RaAddr;
    logic [2:0]         RbAddr;
    logic [7:0]         AluOut;
    logic               WrEn;
    logic [2:0]         WrAddr;
    logic [7:0]         WrData;
    logic               Equals;
    logic               Lt;
    logic [CNT_W-1:0]   RetireCnt;

    modport slave (
        input  Instr, InstrValid, AluOut,
        output InstrReady, AluOp, AluEn, RaAddr, RbAddr,
        output WrEn, WrAddr, WrData, Equals, Lt, RetireCnt
    );

    modport master (
        output Instr, InstrValid, AluOut,
        input  InstrReady, AluOp, AluEn, RaAddr, RbAddr,
        input  WrEn, WrAddr, WrData, Equals, Lt, RetireCnt
    );

endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: IDLE -> EXEC -> WB sequencing, result capture, retire
// counter. Compare flags exist only when ALU_ISSUE_FLAGS_EN is defined.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    alu_issue_ctrl_if.slave   bus
);

    issue_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.InstrValid) begin
                    ir_d    = bus.Instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                wdata_d = bus.AluOut;
                state_d = WB;
            end
            WB: begin
                cnt_d = cnt_q + 1'b1;
                // WB accepts directly so back-to-back issue needs no idle cycle
                if (bus.InstrValid) begin
                    ir_d    = bus.Instr;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InstrReady = (state_q != EXEC);
    assign bus.AluEn      = (state_q == EXEC);
    assign bus.WrEn       = (state_q == WB);
    assign bus.AluOp      = fld(ir_q, OP_LSB);
    assign bus.RaAddr     = fld(ir_q, RD_LSB);
    assign bus.RbAddr     = fld(ir_q, RB_LSB);
    assign bus.WrAddr     = fld(ir_q, RD_LSB);
    assign bus.WrData     = wdata_q;
    assign bus.RetireCnt  = cnt_q;

`ifdef ALU_ISSUE_FLAGS_EN
    logic eq_q, eq_d;
    logic lt_q, lt_d;

    always_comb begin
        eq_d = eq_q;
        lt_d = lt_q;
        if (state_q == EXEC && fld(ir_q, OP_LSB) == mcSUB) begin
            eq_d = (bus.AluOut == 8'd0);
            lt_d = bus.AluOut[7];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            eq_q <= 1'b0;
            lt_q <= 1'b0;
        end else begin
            eq_q <= eq_d;
            lt_q <= lt_d;
        end
    end

    assign bus.Equals = eq_q;
    assign bus.Lt     = lt_q;
`else
    assign bus.Equals = 1'b0;
    assign bus.Lt     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and 8x8 register
// file; flag expectations follow ALU_ISSUE_FLAGS_EN.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int CNT_W = 4;
`ifdef ALU_ISSUE_FLAGS_EN
    localparam logic [31:0] FE = 32'd1;
`else
    localparam logic [31:0] FE = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pl_en;
    logic [2:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] rf [8];
    int         nvec = 0;
    int         nerr = 0;

    alu_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

    alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(
        input logic [2:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {7'd0, ^a};
            3'd6:    return a << b[2:0];
            default: return a >> b[2:0];
        endcase
    endfunction

    always_comb bus.AluOut = alu(bus.AluOp, rf[bus.RaAddr], rf[bus.RbAddr]);

    always @(posedge clk) begin
        if (pl_en)
            rf[pl_addr] <= pl_data;
        else if (bus.WrEn)
            rf[bus.WrAddr] <= bus.WrData;
    end

    function automatic logic [8:0] mk(
        input logic [2:0] op,
        input logic [2:0] rd,
        input logic [2:0] rb
    );
        return {op, rd, rb};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    task automatic exec1(input logic [8:0] ins, input logic [7:0] exp_wd);
        bus.Instr      = ins;
        bus.InstrValid = 1'b1;
        @(posedge clk); #1;
        bus.InstrValid = 1'b0;
        @(negedge clk);
        chk("exec_alu_en", 32'(bus.AluEn), 32'd1);
        chk("exec_ready", 32'(bus.InstrReady), 32'd0);
        chk("exec_wr_en", 32'(bus.WrEn), 32'd0);
        chk("exec_alu_op", 32'(bus.AluOp), 32'(ins[8:6]));
        chk("exec_ra", 32'(bus.RaAddr), 32'(ins[5:3]));
        chk("exec_rb", 32'(bus.RbAddr), 32'(ins[2:0]));
        @(posedge clk); #1;
        @(negedge clk);
        chk("wb_wr_en", 32'(bus.WrEn), 32'd1);
        chk("wb_alu_en", 32'(bus.AluEn), 32'd0);
        chk("wb_ready", 32'(bus.InstrReady), 32'd1);
        chk("wb_addr", 32'(bus.WrAddr), 32'(ins[5:3]));
        chk("wb_data", 32'(bus.WrData), 32'(exp_wd));
        @(posedge clk); #1;
    endtask

    logic [8:0] bb_ins [4];
    logic [7:0] bb_exp [4];

    initial begin
        rst_n          = 1'b0;
        bus.Instr      = '0;
        bus.InstrValid = 1'b0;
        pl_en          = 1'b0;
        pl_addr        = '0;
        pl_data        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        @(negedge clk);
        chk("rst_ready", 32'(bus.InstrReady), 32'd1);
        chk("rst_alu_en", 32'(bus.AluEn), 32'd0);
        chk("rst_wr_en", 32'(bus.WrEn), 32'd0);
        chk("rst_alu_op", 32'(bus.AluOp), 32'd0);
        chk("rst_ra", 32'(bus.RaAddr), 32'd0);
        chk("rst_rb", 32'(bus.RbAddr), 32'd0);
        chk("rst_wr_addr", 32'(bus.WrAddr), 32'd0);
        chk("rst_wr_data", 32'(bus.WrData), 32'd0);
        chk("rst_eq", 32'(bus.Equals), 32'd0);
        chk("rst_lt", 32'(bus.Lt), 32'd0);
        chk("rst_cnt", 32'(bus.RetireCnt), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk); #1;

        // ADD r1,r2 : 5 + 3
        load(3'd1, 8'd5);
        load(3'd2, 8'd3);
        exec1(mk(mcADD, 3'd1, 3'd2), 8'd8);
        chk("add_cnt", 32'(bus.RetireCnt), 32'd1);
        chk("add_rf", 32'(rf[1]), 32'd8);

        // SUB equal operands -> zero
        load(3'd1, 8'd7);
        load(3'd2, 8'd7);
        exec1(mk(mcSUB, 3'd1, 3'd2), 8'd0);
        chk("sub0_eq", 32'(bus.Equals), FE);
        chk("sub0_lt", 32'(bus.Lt), 32'd0);

        // SUB 2 - 5 -> negative
        load(3'd1, 8'd2);
        load(3'd2, 8'd5);
        exec1(mk(mcSUB, 3'd1, 3'd2), 8'hFD);
        chk("subn_eq", 32'(bus.Equals), 32'd0);
        chk("subn_lt", 32'(bus.Lt), FE);

        // XOR with zero result must not touch flags
        load(3'd3, 8'h5A);
        load(3'd4, 8'h5A);
        exec1(mk(mcXOR, 3'd3, 3'd4), 8'h00);
        chk("xor_eq", 32'(bus.Equals), 32'd0);
        chk("xor_lt", 32'(bus.Lt), FE);
        chk("xor_cnt", 32'(bus.RetireCnt), 32'd4);

        // back-to-back issue, next instruction presented during EXEC
        load(3'd1, 8'd1);
        load(3'd2, 8'd2);
        load(3'd3, 8'd3);
        load(3'd4, 8'd4);
        load(3'd5, 8'd5);
        bb_ins[0] = mk(mcADD, 3'd1, 3'd2); bb_exp[0] = 8'd3;
        bb_ins[1] = mk(mcADD, 3'd3, 3'd2); bb_exp[1] = 8'd5;
        bb_ins[2] = mk(mcADD, 3'd4, 3'd2); bb_exp[2] = 8'd6;
        bb_ins[3] = mk(mcADD, 3'd5, 3'd2); bb_exp[3] = 8'd7;
        bus.Instr      = bb_ins[0];
        bus.InstrValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) bus.Instr = bb_ins[i+1];
            else       bus.InstrValid = 1'b0;
            @(negedge clk);
            chk("bb_alu_en", 32'(bus.AluEn), 32'd1);
            chk("bb_ready", 32'(bus.InstrReady), 32'd0);
            chk("bb_ra", 32'(bus.RaAddr), 32'(bb_ins[i][5:3]));
            @(posedge clk); #1;
            @(negedge clk);
            chk("bb_wr_en", 32'(bus.WrEn), 32'd1);
            chk("bb_alu_en_wb", 32'(bus.AluEn), 32'd0);
            chk("bb_wr_addr", 32'(bus.WrAddr), 32'(bb_ins[i][5:3]));
            chk("bb_wr_data", 32'(bus.WrData), 32'(bb_exp[i]));
        end
        @(posedge clk); #1;
        chk("bb_cnt", 32'(bus.RetireCnt), 32'd8);
        chk("bb_rf5", 32'(rf[5]), 32'd7);
        chk("bb_idle", 32'(dut.state_q), 32'(IDLE));

        // reset pulsed in EXEC drops the pending write
        bus.Instr      = mk(mcADD, 3'd1, 3'd2);
        bus.InstrValid = 1'b1;
        @(posedge clk); #1;
        bus.InstrValid = 1'b0;
        @(negedge clk);
        chk("mid_alu_en", 32'(bus.AluEn), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_en", 32'(bus.AluEn), 32'd0);
        chk("mid_rst_wr_en", 32'(bus.WrEn), 32'd0);
        chk("mid_rst_ready", 32'(bus.InstrReady), 32'd1);
        chk("mid_rst_cnt", 32'(bus.RetireCnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_wr_en", 32'(bus.WrEn), 32'd0);
        chk("mid_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_rf1", 32'(rf[1]), 32'd3);
        @(posedge clk); #1;

        // 17 retires on a 4-bit counter
        for (int k = 0; k < 17; k++) begin
            bus.Instr      = mk(mcADD, 3'd7, 3'd0);
            bus.InstrValid = 1'b1;
            @(posedge clk); #1;
            bus.InstrValid = 1'b0;
            @(posedge clk); #1;
            if (k == 16)
                chk("wrap_zero", 32'(bus.RetireCnt), 32'd0);
        end
        @(posedge clk); #1;
        chk("wrap_cnt", 32'(bus.RetireCnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
